// File: rtl/quad_velocity_meter_if.sv
// Quadrature velocity meter bus.
// Carries the encoder pins, the control inputs and the measurement results
// between the host (master) and the meter (slave).
//   i_enc_a, i_enc_b : raw encoder channels (asynchronous to the clock)
//   i_enable         : velocity windowing enable
//   i_clr_pos        : synchronous, level-sensitive position clear
//   o_pv, o_dir      : |velocity| and direction of the last completed window
//   o_valid          : one-cycle strobe when o_pv/o_dir update
//   o_pos            : signed absolute position in x4 counts
//   o_err            : sticky illegal-transition flag
interface quad_velocity_meter_if #(
   parameter int POS_W = 32
);
   logic             i_enc_a;
   logic             i_enc_b;
   logic             i_enable;
   logic             i_clr_pos;
   logic [15:0]      o_pv;
   logic             o_dir;
   logic             o_valid;
   logic [POS_W-1:0] o_pos;
   logic             o_err;

   modport master (
      output i_enc_a, i_enc_b, i_enable, i_clr_pos,
      input  o_pv, o_dir, o_valid, o_pos, o_err
   );

   modport slave (
      input  i_enc_a, i_enc_b, i_enable, i_clr_pos,
      output o_pv, o_dir, o_valid, o_pos, o_err
   );
endinterface

// File: rtl/quad_velocity_meter.sv
// Quadrature encoder front end producing the PID process value.
// Synchronises and debounces the A/B channels, decodes x4 quadrature into
// an absolute position, and counts signed edges over a fixed window to
// publish |velocity| with a one-cycle valid strobe.
//   i_clk : system clock
//   i_rst : asynchronous active-low reset
//   bus   : quad_velocity_meter_if slave (encoder pins, controls, results)
module quad_velocity_meter #(
   parameter int SAMPLE_CYCLES = 12000,
   parameter int FILTER_LEN    = 3,
   parameter int POS_W         = 32
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   quad_velocity_meter_if.slave   bus
);

   localparam int              CW   = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam logic [CW-1:0]   LAST = CW'(SAMPLE_CYCLES - 1);
   localparam logic [3:0]      FLIM = 4'(FILTER_LEN - 1);

   // Index 1 = channel A, index 0 = channel B, so {A,B} reads naturally.
   logic [1:0]        sync1;
   logic [1:0]        sync2;
   logic [1:0]        filt;
   logic [3:0]        fcnt [2];
   logic [1:0]        prev;

   logic [CW-1:0]     win_cnt;
   logic signed [16:0] acc;

   logic [15:0]       pv_q;
   logic              dir_q;
   logic              valid_q;
   logic [POS_W-1:0]  pos_q;
   logic              err_q;

   logic [1:0]        step;
   logic signed [1:0] delta;
   logic              illegal;
   logic signed [17:0] sum;
   logic signed [16:0] acc_sat;
   logic [17:0]       mag;
   logic [15:0]       pv_next;

   // Map Gray states to a ring index so the signed step falls out of a
   // 2-bit subtraction: 1 = forward, 3 = reverse, 2 = both bits changed.
   function automatic logic [1:0] phase(input logic [1:0] ab);
      case (ab)
         2'b00:   phase = 2'd0;
         2'b10:   phase = 2'd1;
         2'b11:   phase = 2'd2;
         default: phase = 2'd3;
      endcase
   endfunction

   always_comb begin
      step    = phase(filt) - phase(prev);
      delta   = 2'sb00;
      illegal = 1'b0;
      case (step)
         2'd1:    delta   = 2'sb01;
         2'd3:    delta   = 2'sb11;
         2'd2:    illegal = 1'b1;
         default: delta   = 2'sb00;
      endcase
   end

   // 18-bit sum covers +/-65536 before saturation back into 17 bits.
   always_comb begin
      sum = {acc[16], acc} + {{16{delta[1]}}, delta};
      if (sum > 18'sd65535)
         acc_sat = 17'sd65535;
      else if (sum < -18'sd65535)
         acc_sat = -17'sd65535;
      else
         acc_sat = sum[16:0];
      mag = sum[17] ? 18'(-sum) : 18'(sum);
      pv_next = (mag > 18'd65535) ? 16'hFFFF : mag[15:0];
   end

   // Synchroniser and per-channel stability filter.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sync1 <= '0;
         sync2 <= '0;
         filt  <= '0;
         for (int unsigned ch = 0; ch < 2; ch++)
            fcnt[ch] <= '0;
      end else begin
         sync1 <= {bus.i_enc_a, bus.i_enc_b};
         sync2 <= sync1;
         for (int unsigned ch = 0; ch < 2; ch++) begin
            if (sync2[ch] != filt[ch]) begin
               if (fcnt[ch] == FLIM) begin
                  filt[ch] <= sync2[ch];
                  fcnt[ch] <= '0;
               end else begin
                  fcnt[ch] <= fcnt[ch] + 4'd1;
               end
            end else begin
               fcnt[ch] <= '0;
            end
         end
      end
   end

   // Decode history, position and sticky error.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         prev  <= '0;
         pos_q <= '0;
         err_q <= 1'b0;
      end else begin
         prev <= filt;
         if (illegal)
            err_q <= 1'b1;
         if (bus.i_clr_pos)
            pos_q <= '0;
         else
            pos_q <= pos_q + {{(POS_W-2){delta[1]}}, delta};
      end
   end

   // Velocity window; the boundary-cycle delta is folded into the closing window.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         win_cnt <= '0;
         acc     <= '0;
         pv_q    <= '0;
         dir_q   <= 1'b0;
         valid_q <= 1'b0;
      end else if (!bus.i_enable) begin
         win_cnt <= '0;
         acc     <= '0;
         valid_q <= 1'b0;
      end else if (win_cnt == LAST) begin
         win_cnt <= '0;
         acc     <= '0;
         pv_q    <= pv_next;
         dir_q   <= sum[17];
         valid_q <= 1'b1;
      end else begin
         win_cnt <= win_cnt + CW'(1);
         acc     <= acc_sat;
         valid_q <= 1'b0;
      end
   end

   assign bus.o_pv    = pv_q;
   assign bus.o_dir   = dir_q;
   assign bus.o_valid = valid_q;
   assign bus.o_pos   = pos_q;
   assign bus.o_err   = err_q;

endmodule

// File: tb/tb_quad_velocity_meter.sv
module tb_quad_velocity_meter;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   quad_velocity_meter_if #(.POS_W(32)) bus ();

   quad_velocity_meter #(
      .SAMPLE_CYCLES(100),
      .FILTER_LEN(3),
      .POS_W(32)
   ) dut (
      .i_clk(clk),
      .i_rst(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Counts negedges until o_valid is seen, giving up after 300.
   task automatic wait_strobe(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.o_valid && n < 300);
   endtask

   task automatic step_ab(input logic a, input logic b, input int gap);
      bus.i_enc_a = a;
      bus.i_enc_b = b;
      tick(gap);
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      bus.i_enc_a = 1'b0;
      bus.i_enc_b = 1'b0;
      bus.i_enable = 1'b1;
      bus.i_clr_pos = 1'b0;
      tick(10);
      total++;
      if ({bus.o_pv, bus.o_dir, bus.o_valid, bus.o_err} !== 19'd0 || bus.o_pos !== 32'd0) begin
         bad++;
         $display("FAIL reset_outputs: pv=%0d dir=%0b valid=%0b pos=%0d err=%0b, want all 0",
                  bus.o_pv, bus.o_dir, bus.o_valid, bus.o_pos, bus.o_err);
      end
      rst_n = 1'b1;
      wait_strobe(n);
      total++;
      if (n !== 100) begin
         bad++;
         $display("FAIL reset_first_strobe: got %0d cycles, want 100", n);
      end
      total++;
      if (bus.o_pv !== 16'd0 || bus.o_dir !== 1'b0) begin
         bad++;
         $display("FAIL reset_first_pv: pv=%0d dir=%0b, want 0/0", bus.o_pv, bus.o_dir);
      end
   endtask

   task automatic test_forward();
      int n;
      // From 00: 10,11,01,00,10,11,01,00,10,11
      step_ab(1, 0, 8); step_ab(1, 1, 8); step_ab(0, 1, 8); step_ab(0, 0, 8);
      step_ab(1, 0, 8); step_ab(1, 1, 8); step_ab(0, 1, 8); step_ab(0, 0, 8);
      step_ab(1, 0, 8); step_ab(1, 1, 8);
      total++;
      if (bus.o_pos !== 32'd10) begin
         bad++;
         $display("FAIL fwd_pos: got %0d, want 10", $signed(bus.o_pos));
      end
      wait_strobe(n);
      total++;
      if (n !== 20) begin
         bad++;
         $display("FAIL fwd_strobe_time: got %0d cycles, want 20", n);
      end
      total++;
      if (bus.o_pv !== 16'd10 || bus.o_dir !== 1'b0) begin
         bad++;
         $display("FAIL fwd_pv: pv=%0d dir=%0b, want 10/0", bus.o_pv, bus.o_dir);
      end
      tick(1);
      total++;
      if (bus.o_valid !== 1'b0 || bus.o_pv !== 16'd10) begin
         bad++;
         $display("FAIL fwd_strobe_width: valid=%0b pv=%0d, want 0/10", bus.o_valid, bus.o_pv);
      end
      wait_strobe(n);
      total++;
      if (n !== 99 || bus.o_pv !== 16'd0 || bus.o_dir !== 1'b0) begin
         bad++;
         $display("FAIL idle_window: cycles=%0d pv=%0d dir=%0b, want 99/0/0", n, bus.o_pv, bus.o_dir);
      end
   endtask

   task automatic test_reverse();
      int n;
      // From 11: 10,00,01,11,10,00,01
      step_ab(1, 0, 8); step_ab(0, 0, 8); step_ab(0, 1, 8); step_ab(1, 1, 8);
      step_ab(1, 0, 8); step_ab(0, 0, 8); step_ab(0, 1, 8);
      total++;
      if (bus.o_pos !== 32'd3) begin
         bad++;
         $display("FAIL rev_pos: got %0d, want 3", $signed(bus.o_pos));
      end
      wait_strobe(n);
      total++;
      if (n !== 44 || bus.o_pv !== 16'd7 || bus.o_dir !== 1'b1) begin
         bad++;
         $display("FAIL rev_pv: cycles=%0d pv=%0d dir=%0b, want 44/7/1", n, bus.o_pv, bus.o_dir);
      end
   endtask

   task automatic test_enable();
      int n;
      int seen = 0;
      bus.i_enable = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (bus.o_valid) seen++;
      end
      total++;
      if (seen !== 0 || bus.o_pv !== 16'd7 || bus.o_dir !== 1'b1) begin
         bad++;
         $display("FAIL disabled_hold: strobes=%0d pv=%0d dir=%0b, want 0/7/1", seen, bus.o_pv, bus.o_dir);
      end
      bus.i_enable = 1'b1;
      wait_strobe(n);
      total++;
      if (n !== 100 || bus.o_pv !== 16'd0 || bus.o_dir !== 1'b0) begin
         bad++;
         $display("FAIL reenable_strobe: cycles=%0d pv=%0d dir=%0b, want 100/0/0", n, bus.o_pv, bus.o_dir);
      end
   endtask

   task automatic test_glitch();
      // State 01, pos 3. Two-cycle pulse on A must be filtered out.
      bus.i_enc_a = 1'b1;
      tick(2);
      bus.i_enc_a = 1'b0;
      tick(10);
      total++;
      if (bus.o_pos !== 32'd3) begin
         bad++;
         $display("FAIL glitch_pos: got %0d, want 3", $signed(bus.o_pos));
      end
      // 01 -> 00 is a forward step; must land exactly 6 cycles after the pin edge.
      bus.i_enc_b = 1'b0;
      tick(5);
      total++;
      if (bus.o_pos !== 32'd3) begin
         bad++;
         $display("FAIL latency_early: got %0d after 5 cycles, want 3", $signed(bus.o_pos));
      end
      tick(1);
      total++;
      if (bus.o_pos !== 32'd4) begin
         bad++;
         $display("FAIL latency_6: got %0d after 6 cycles, want 4", $signed(bus.o_pos));
      end
   endtask

   task automatic test_illegal_clr();
      // 00 -> 11 on the same cycle.
      total++;
      if (bus.o_err !== 1'b0) begin
         bad++;
         $display("FAIL err_before: got %0b, want 0", bus.o_err);
      end
      step_ab(1, 1, 8);
      total++;
      if (bus.o_err !== 1'b1 || bus.o_pos !== 32'd4) begin
         bad++;
         $display("FAIL illegal: err=%0b pos=%0d, want 1/4", bus.o_err, $signed(bus.o_pos));
      end
      // 11 -> 01 forward; clear lands on the cycle that delta is applied.
      bus.i_enc_a = 1'b0;
      tick(5);
      total++;
      if (bus.o_pos !== 32'd4) begin
         bad++;
         $display("FAIL clr_pre: got %0d, want 4", $signed(bus.o_pos));
      end
      bus.i_clr_pos = 1'b1;
      tick(1);
      bus.i_clr_pos = 1'b0;
      tick(3);
      total++;
      if (bus.o_pos !== 32'd0 || bus.o_err !== 1'b1) begin
         bad++;
         $display("FAIL clr_priority: pos=%0d err=%0b, want 0/1", $signed(bus.o_pos), bus.o_err);
      end
   endtask

   task automatic test_midwindow_reset();
      int n;
      wait_strobe(n);
      total++;
      if (n >= 300) begin
         bad++;
         $display("FAIL sync_timeout: got %0d cycles, want < 300", n);
      end
      // From 01: 00,10,11,01,00 -> pins end at 00.
      step_ab(0, 0, 8); step_ab(1, 0, 8); step_ab(1, 1, 8); step_ab(0, 1, 8); step_ab(0, 0, 8);
      tick(10);
      total++;
      if (bus.o_pos !== 32'd5) begin
         bad++;
         $display("FAIL mid_pos: got %0d, want 5", $signed(bus.o_pos));
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.o_pv, bus.o_dir, bus.o_valid, bus.o_err} !== 19'd0 || bus.o_pos !== 32'd0) begin
         bad++;
         $display("FAIL async_clear: pv=%0d dir=%0b valid=%0b pos=%0d err=%0b, want all 0",
                  bus.o_pv, bus.o_dir, bus.o_valid, $signed(bus.o_pos), bus.o_err);
      end
      tick(3);
      rst_n = 1'b1;
      wait_strobe(n);
      total++;
      if (n !== 100 || bus.o_pv !== 16'd0 || bus.o_dir !== 1'b0 || bus.o_pos !== 32'd0) begin
         bad++;
         $display("FAIL post_reset_strobe: cycles=%0d pv=%0d dir=%0b pos=%0d, want 100/0/0/0",
                  n, bus.o_pv, bus.o_dir, $signed(bus.o_pos));
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_enable();
      test_glitch();
      test_illegal_clr();
      test_midwindow_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
